d_branch_ctrl: RTL and testbench

D_BRANCH_CTRL -- requirements
Module: d_branch_ctrl

---
 rtl/d_branch_ctrl_pkg.sv | 20 ++
 rtl/d_branch_ctrl_cmp.sv | 17 +
 rtl/d_branch_ctrl.sv | 138 +++++++++++++
 tb/tb_d_branch_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/d_branch_ctrl_pkg.sv
// Shared constants for the D-stage branch controller: compare selects,
// FSM state encoding, PC increment and the branch-offset helper.
package d_branch_ctrl_pkg;

  localparam logic [2:0]  BEQ_CMP = 3'b000;
  localparam logic [2:0]  BNE_CMP = 3'b001;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_SLOT = 2'b10
  } br_state_e;

  // Word offset: sign-extend the 16-bit immediate and scale by 4.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/d_branch_ctrl_cmp.sv
// Branch operand comparator: BNE is taken on inequality, every other select
// (BEQ and the unused encodings) is taken on equality.
module d_br_cmp
  import d_branch_ctrl_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [2:0]  cmp_sel,
  output logic        taken
);

  always_comb begin
    taken = (op_a == op_b);
    if (cmp_sel == BNE_CMP) taken = (op_a != op_b);
  end

endmodule

// File: rtl/d_branch_ctrl.sv
// D-stage branch resolution: waits for operands (bounded by MAX_WAIT), then
// redirects for one SLOT cycle. Optional statistics under D_BRANCH_STAT_EN.
module d_branch_ctrl
  import d_branch_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        D_br_valid,
  input  logic [2:0]  s_D_cmp,
  input  logic [31:0] D_Rdata1,
  input  logic [31:0] D_Rdata2,
  input  logic        D_rs_ready,
  input  logic        D_rt_ready,
  input  logic [31:0] D_pc,
  input  logic [15:0] D_imm16,
  output logic        D_stall,
  output logic        npc_sel,
  output logic [31:0] D_npc,
  output logic        D_br_err
`ifdef D_BRANCH_STAT_EN
  ,
  output logic [31:0] br_cnt,
  output logic [31:0] taken_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  br_state_e   state, state_nx;
  logic [3:0]  wait_cnt, wait_cnt_nx;
  logic        taken_q, taken_nx;
  logic [31:0] tgt_q, tgt_nx;
  logic        err_q, err_nx;
  logic        cmp_taken;
  logic        both_ready;
  logic [31:0] tgt_calc;

  assign both_ready = D_rs_ready && D_rt_ready;
  assign tgt_calc   = D_pc + PC_INC + br_offset(D_imm16);

  d_br_cmp u_cmp (
    .op_a    (D_Rdata1),
    .op_b    (D_Rdata2),
    .cmp_sel (s_D_cmp),
    .taken   (cmp_taken)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      taken_q  <= 1'b0;
      tgt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      taken_q  <= taken_nx;
      tgt_q    <= tgt_nx;
      err_q    <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    taken_nx    = taken_q;
    tgt_nx      = tgt_q;
    err_nx      = 1'b0;
    D_stall     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (D_br_valid) begin
          if (both_ready) begin
            taken_nx = cmp_taken;
            tgt_nx   = tgt_calc;
            state_nx = ST_SLOT;
          end else begin
            D_stall     = 1'b1;
            wait_cnt_nx = 4'd1;
            state_nx    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Flush takes priority; ready operands win over an expiring counter.
        if (!D_br_valid) begin
          wait_cnt_nx = '0;
          state_nx    = ST_IDLE;
        end else if (both_ready) begin
          taken_nx    = cmp_taken;
          tgt_nx      = tgt_calc;
          wait_cnt_nx = '0;
          state_nx    = ST_SLOT;
        end else if (wait_cnt < MAX_W) begin
          D_stall     = 1'b1;
          wait_cnt_nx = wait_cnt + 4'd1;
        end else begin
          err_nx      = 1'b1;
          taken_nx    = 1'b0;
          tgt_nx      = tgt_calc;
          wait_cnt_nx = '0;
          state_nx    = ST_SLOT;
        end
      end
      ST_SLOT: begin
        err_nx   = D_br_valid;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign npc_sel  = (state == ST_SLOT) && taken_q;
  assign D_npc    = tgt_q;
  assign D_br_err = err_q;

`ifdef D_BRANCH_STAT_EN
  logic resolved;
  assign resolved = D_br_valid && both_ready && (state != ST_SLOT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (resolved)              br_cnt    <= br_cnt + 32'd1;
      if (resolved && cmp_taken) taken_cnt <= taken_cnt + 32'd1;
      if (D_stall)               stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_d_branch_ctrl.sv
// Self-checking bench for d_branch_ctrl: directed corner cases plus random
// branch transactions predicted from operand-ready delay, compare and offset.
module tb_d_branch_ctrl;

  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        D_br_valid = 1'b0;
  logic [2:0]  s_D_cmp = '0;
  logic [31:0] D_Rdata1 = '0;
  logic [31:0] D_Rdata2 = '0;
  logic        D_rs_ready = 1'b1;
  logic        D_rt_ready = 1'b1;
  logic [31:0] D_pc = '0;
  logic [15:0] D_imm16 = '0;
  logic        D_stall;
  logic        npc_sel;
  logic [31:0] D_npc;
  logic        D_br_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_tgt = '0;
  bit          tgt_known = 1'b1;

  d_branch_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .D_br_valid (D_br_valid),
    .s_D_cmp    (s_D_cmp),
    .D_Rdata1   (D_Rdata1),
    .D_Rdata2   (D_Rdata2),
    .D_rs_ready (D_rs_ready),
    .D_rt_ready (D_rt_ready),
    .D_pc       (D_pc),
    .D_imm16    (D_imm16),
    .D_stall    (D_stall),
    .npc_sel    (npc_sel),
    .D_npc      (D_npc),
    .D_br_err   (D_br_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One branch transaction. k = cycles the operands stay not-ready,
  // flush_at (>0) drops D_br_valid after that many stalled cycles,
  // ds puts another branch in the delay slot, side picks the late operand.
  task automatic run_branch(input logic [2:0] cmp, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [15:0] imm,
                            input int unsigned k, input int unsigned flush_at,
                            input bit ds, input int unsigned side);
    int unsigned stalls;
    bit          timeout;
    bit          exp_taken;
    logic [31:0] exp_tgt;
    stalls    = (k < MAX_WAIT) ? k : MAX_WAIT;
    timeout   = (k > MAX_WAIT);
    exp_taken = (cmp == 3'b001) ? (a != b) : (a == b);
    exp_tgt   = pc + 32'd4 + 32'($signed(imm)) * 32'd4;

    s_D_cmp = cmp; D_Rdata1 = a; D_Rdata2 = b; D_pc = pc; D_imm16 = imm;
    D_br_valid = 1'b1;
    for (int unsigned c = 1; c <= stalls + 1; c++) begin
      bool_flush: begin end
      if (flush_at != 0 && c == flush_at + 1) D_br_valid = 1'b0;
      D_rs_ready = (side == 1) ? 1'b1 : (c > k);
      D_rt_ready = (side == 0) ? 1'b1 : (c > k);
      @(negedge clk);
      check("stall", D_stall, (c <= stalls) && !(flush_at != 0 && c == flush_at + 1));
      check("npc_sel_wait", npc_sel, 1'b0);
      check("err_wait", D_br_err, 1'b0);
      @(posedge clk); #1;
      if (flush_at != 0 && c == flush_at + 1) break;
    end

    if (flush_at != 0) begin
      D_br_valid = 1'b0;
      @(negedge clk);
      check("npc_sel_flush", npc_sel, 1'b0);
      check("err_flush", D_br_err, 1'b0);
      if (tgt_known) check("npc_hold_flush", D_npc, last_tgt);
      @(posedge clk); #1;
      return;
    end

    // SLOT cycle, optionally with a branch sitting in the delay slot
    D_br_valid = ds; D_rs_ready = 1'b1; D_rt_ready = 1'b1;
    D_Rdata1 = $urandom; D_Rdata2 = D_Rdata1; D_pc = $urandom; D_imm16 = 16'($urandom);
    @(negedge clk);
    check("npc_sel_slot", npc_sel, !timeout && exp_taken);
    check("stall_slot", D_stall, 1'b0);
    check("err_slot", D_br_err, timeout);
    if (!timeout) begin
      check("npc_slot", D_npc, exp_tgt);
      last_tgt  = exp_tgt;
      tgt_known = 1'b1;
    end else begin
      tgt_known = 1'b0;
    end
    @(posedge clk); #1;

    D_br_valid = 1'b0;
    @(negedge clk);
    check("npc_sel_after", npc_sel, 1'b0);
    check("err_after", D_br_err, ds);
    check("stall_after", D_stall, 1'b0);
    if (tgt_known) check("npc_hold", D_npc, last_tgt);
    @(posedge clk); #1;
  endtask

  task automatic check_quiet(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_npc_sel"}, npc_sel, 1'b0);
      check({tag, "_err"}, D_br_err, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #3;
    check("rst_npc_sel", npc_sel, 1'b0);
    check("rst_npc", D_npc, 32'h0);
    check("rst_err", D_br_err, 1'b0);
    check("rst_stall", D_stall, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_branch(3'b000, 32'h1234, 32'h1234, 32'h3000, 16'h0004, 0, 0, 0, 2);
    run_branch(3'b001, 32'd5, 32'd5, 32'h3000, 16'h0010, 0, 0, 0, 2);
    run_branch(3'b111, 32'd5, 32'd5, 32'h4000, 16'h0001, 0, 0, 0, 2);
    run_branch(3'b000, 32'h80000000, 32'h0, 32'h100, 16'h2, 0, 0, 0, 2);
    run_branch(3'b000, 32'hAA, 32'hAA, 32'h3000, 16'h0004, 2, 0, 0, 0);
    run_branch(3'b000, 32'hAA, 32'hAA, 32'h3000, 16'h0004, MAX_WAIT, 0, 0, 1);
    run_branch(3'b000, 32'h1, 32'h1, 32'h5000, 16'h0008, 50, 0, 0, 2);
    run_branch(3'b001, 32'h1, 32'h2, 32'hFFFFFFF8, 16'h0001, 0, 0, 0, 2);
    run_branch(3'b000, 32'h7, 32'h7, 32'h3000, 16'h8000, 0, 0, 1, 2);
    run_branch(3'b000, 32'h7, 32'h7, 32'h6000, 16'h0003, 3, 2, 0, 0);

    // async reset while waiting for operands
    D_br_valid = 1'b1; D_rs_ready = 1'b0; D_rt_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rstw_npc_sel", npc_sel, 1'b0);
    check("rstw_npc", D_npc, 32'h0);
    check("rstw_err", D_br_err, 1'b0);
    D_br_valid = 1'b0; D_rs_ready = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    last_tgt = '0; tgt_known = 1'b1;
    check_quiet(3, "post_rstw");

    // async reset in the middle of a taken SLOT
    s_D_cmp = 3'b000; D_Rdata1 = 32'h9; D_Rdata2 = 32'h9; D_pc = 32'h200; D_imm16 = 16'h1;
    D_br_valid = 1'b1;
    @(posedge clk); #1;
    D_br_valid = 1'b0;
    check("slot_pre_rst_npc_sel", npc_sel, 1'b1);
    check("slot_pre_rst_npc", D_npc, 32'h208);
    #1 reset_n = 1'b0;
    #1;
    check("rsts_npc_sel", npc_sel, 1'b0);
    check("rsts_npc", D_npc, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_quiet(3, "post_rsts");

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  cmp;
      logic [31:0] a, b;
      int unsigned k, fl;
      cmp = 3'($urandom_range(0, 7));
      a   = $urandom;
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      k  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7);
      fl = (k > 0 && $urandom_range(0, 4) == 0) ?
           $urandom_range(1, (k < MAX_WAIT) ? k : MAX_WAIT) : 0;
      run_branch(cmp, a, b, $urandom, 16'($urandom), k, fl,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) check_quiet(1, "gap");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
